uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, range 2..16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of flops in the serial-line synchronizer, minimum 2.
REQ-003 SHALL have port clk  input  1  clock, all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  receive enable from software.
REQ-006 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port uart_rx_enable  output  1  drives the receiver's enable input.
REQ-008 SHALL have port uart_rx_start  output  1  one-cycle pulse that launches one frame reception.
REQ-009 SHALL have port uart_rx_busy  input  1  receiver busy.
REQ-010 SHALL have port uart_rx_done  input  1  receiver frame-complete pulse, one cycle.
REQ-011 SHALL have port uart_rx_data  input  8  received byte, valid with uart_rx_done.
REQ-012 SHALL have port uart_parity_err  input  1  parity error, valid with uart_rx_done.
REQ-013 SHALL have port uart_framing_err  input  1  framing error, valid with uart_rx_done.
REQ-014 SHALL have port m_valid  output  1  FIFO head valid.
REQ-015 SHALL have port m_ready  input  1  consumer accepts head.
REQ-016 SHALL have port m_data  output  8  FIFO head byte.
REQ-017 SHALL have port m_err  output  2  FIFO head errors {parity, framing}.
REQ-018 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-019 SHALL have port overflow  output  1  sticky overflow flag.
REQ-020 SHALL have port ovf_clr  input  1  clears overflow.
REQ-021 SHALL have port irq  output  1  interrupt, registered.

Function
REQ-022 SHALL synchronize rx_in through SYNC_STAGES flops, reset value 1, giving rx_s; all line decisions use rx_s only.
REQ-023 SHALL implement FSM states IDLE, ARM, WAIT_START, LAUNCH, BUSY.
- IDLE: en=1 -> ARM.
- ARM: rx_s=1 for 1 cycle -> WAIT_START; guards against a line stuck low at enable.
- WAIT_START: rx_s falling edge (previous 1, current 0) -> LAUNCH.
- LAUNCH: uart_rx_start=1 for exactly this cycle -> BUSY.
- BUSY: uart_rx_done=1 -> WAIT_START if en=1, else IDLE.
REQ-024 SHALL assert uart_rx_enable registered from en, except it stays 1 while state is LAUNCH or BUSY.
REQ-025 SHALL, in ARM or WAIT_START with en=0, return to IDLE the next cycle, with no uart_rx_start.
REQ-026 SHALL ignore rx_s activity while in LAUNCH or BUSY.
REQ-027 SHALL never have more than one frame outstanding; uart_rx_start SHALL NOT pulse while uart_rx_busy=1.
REQ-028 SHALL push {uart_parity_err, uart_framing_err, uart_rx_data} on the uart_rx_done cycle; the entry is visible on m_* the next cycle.
REQ-029 SHALL pop on m_valid & m_ready; m_data and m_err are the head entry, with first-word fall-through.
REQ-030 SHALL, on push while full with no pop, drop the new entry and set overflow; FIFO contents are unchanged.
REQ-031 SHALL, on push and pop in the same cycle while full, accept both; level is unchanged and overflow is not set.
REQ-032 SHALL, on push and pop in the same cycle while empty, make no bypass: the entry is written and m_valid rises next cycle.
REQ-033 SHALL wrap pointers modulo FIFO_DEPTH.
REQ-034 SHALL have fifo_level in range 0..FIFO_DEPTH, and m_valid = (fifo_level != 0).
REQ-035 SHALL clear overflow on ovf_clr; if ovf_clr and a new overflow occur in the same cycle, set wins.
REQ-036 SHALL set irq next cycle to m_valid | overflow.

Reset
REQ-037 SHALL reset asynchronously: state=IDLE, FIFO empty, pointers 0, uart_rx_enable=0, uart_rx_start=0, m_valid=0, m_data=0, m_err=0, fifo_level=0, overflow=0, irq=0, synchronizer=1.
REQ-038 SHALL, when reset is asserted mid-frame, discard the frame; after release the FSM restarts from IDLE and requires ARM.

Configuration
REQ-039 SHALL, with macro UART_RX_CTRL_ERR_DROP_EN defined, not push frames with either error bit set; such frames pulse no push, and m_err is always 0.
REQ-040 SHALL, with UART_RX_CTRL_ERR_DROP_EN undefined, push all frames with their error bits, per REQ-028.

Verification
REQ-041 SHALL cover: en=1, line idle, then rx_in falls -> one uart_rx_start pulse SYNC_STAGES+1 cycles after the edge; done with data 0xA5 -> m_valid=1, m_data=0xA5, m_err=00.
REQ-042 SHALL cover: 5 frames 0x01..0x05 with m_ready=0 and FIFO_DEPTH=4 -> fifo_level=4, overflow=1, irq=1; drain yields 0x01..0x04.
REQ-043 SHALL cover: full FIFO, m_ready=1 in the same cycle as done with 0x77 -> level stays 4, overflow=0, 0x77 at tail.
REQ-044 SHALL cover: done with parity error, data 0x3C -> m_err=10 without the macro; no push with UART_RX_CTRL_ERR_DROP_EN.
REQ-045 SHALL cover: en dropped in BUSY -> no further start, IDLE after done, last byte still pushed; rx_in held low at enable -> no start until the line returns high then falls.
REQ-046 SHALL cover: resetn asserted in BUSY -> all outputs at reset values immediately, with no push from a later stale done.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Purpose : control around a UART receiver: line synchronizer, start-edge detect
//           FSM that launches one frame at a time, and a receive FIFO with
//           overflow tracking and a registered interrupt.
// Latency : start pulse SYNC_STAGES+1 cycles after rx_in falls; received byte
//           visible on m_* the cycle after uart_rx_done.
// Backpressure: m_valid/m_ready pop; a push into a full FIFO without a
//           simultaneous pop is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, resetn              clock, async active-low reset
//   en                       software receive enable
//   rx_in                    raw serial line (idle high)
//   uart_rx_enable/_start    receiver enable level and per-frame launch pulse
//   uart_rx_busy/_done/_data receiver status and result
//   uart_parity_err/_framing_err  result error flags, valid with done
//   m_valid/m_ready/m_data/m_err  FIFO head (first-word fall-through)
//   fifo_level               FIFO occupancy
//   overflow/ovf_clr         sticky overflow flag and its clear
//   irq                      registered m_valid | overflow
//
// Build option: define UART_RX_CTRL_ERR_DROP_EN to discard frames carrying a
// parity or framing error instead of storing them.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        en,
  input  logic                        rx_in,
  output logic                        uart_rx_enable,
  output logic                        uart_rx_start,
  input  logic                        uart_rx_busy,
  input  logic                        uart_rx_done,
  input  logic [7:0]                  uart_rx_data,
  input  logic                        uart_parity_err,
  input  logic                        uart_framing_err,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [7:0]                  m_data,
  output logic [1:0]                  m_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic                        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_START, S_LAUNCH, S_BUSY
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic                   en_q, en_d;
  logic [9:0]             mem_q [FIFO_DEPTH];
  logic [9:0]             mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   irq_q, irq_d;

  logic       rx_s, rx_fall, in_frame;
  logic       push_req, do_push, do_pop, full, ovf_set;
  logic [9:0] wr_dat, head;

  // Line synchronizer and falling-edge detect on the synchronized line.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx_in};
    rx_prev_d = rx_s;
    en_d      = en;
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign rx_fall = rx_prev_q & ~rx_s;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic. ARM waits for an idle-high line so a line stuck low at
  // enable cannot be mistaken for a start bit. The busy guard keeps at most
  // one frame outstanding even if the receiver is still finishing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (en) state_d = S_ARM;
      S_ARM:        if (!en) state_d = S_IDLE;
                    else if (rx_s) state_d = S_WAIT_START;
      S_WAIT_START: if (!en) state_d = S_IDLE;
                    else if (rx_fall && !uart_rx_busy) state_d = S_LAUNCH;
      S_LAUNCH:     state_d = S_BUSY;
      S_BUSY:       if (uart_rx_done) state_d = en ? S_WAIT_START : S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Outputs: the receiver stays enabled for the whole frame even if software
  // withdraws en, so an in-flight byte is completed and stored.
  always_comb begin
    in_frame       = (state_q == S_LAUNCH) || (state_q == S_BUSY);
    uart_rx_start  = (state_q == S_LAUNCH);
    uart_rx_enable = en_q | in_frame;
  end

  // Receive FIFO. Only a done seen in BUSY is a push, so a done arriving
  // after a reset that discarded its frame is ignored.
  always_comb begin
    push_req = (state_q == S_BUSY) && uart_rx_done;
`ifdef UART_RX_CTRL_ERR_DROP_EN
    wr_dat   = {2'b00, uart_rx_data};
    if (uart_parity_err || uart_framing_err) push_req = 1'b0;
`else
    wr_dat   = {uart_parity_err, uart_framing_err, uart_rx_data};
`endif
    full    = (count_q == LW'(FIFO_DEPTH));
    do_pop  = m_valid & m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push = push_req & (~full | do_pop);
    ovf_set = push_req & full & ~do_pop;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new overflow in the same cycle as a clear keeps the flag set.
    overflow_d = ovf_set | (overflow_q & ~ovf_clr);
    irq_d      = m_valid | overflow_q;
  end

  assign head       = mem_q[rd_ptr_q];
  assign m_valid    = (count_q != '0);
  assign m_data     = m_valid ? head[7:0] : 8'h00;
  assign m_err      = m_valid ? head[9:8] : 2'b00;
  assign fifo_level = count_q;
  assign overflow   = overflow_q;
  assign irq        = irq_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      en_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      en_q       <= en_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
      mem_q      <= mem_d;
    end
  end

endmodule
